// File: rtl/fpu_div.sv
// fpu_div -- iterative IEEE 754 single-precision divider (outp = A / B).
//
// A restoring mantissa divider produces one quotient bit per clock. The
// 25-bit quotient is then normalised and truncated (round toward zero).
// A start/busy/done handshake launches one division; start is sampled only
// while idle. The exponent wraps modulo 256 unless special handling is built in.
//
// Build option (macro FPU_DIV_SPECIAL_EN):
//   defined   - zero/inf/NaN operands are decoded and resolve at the accepting
//               edge; the normal path saturates exponent overflow to inf and
//               underflow to zero.
//   undefined - every operand is taken as {1,mantissa}; 26-cycle latency always.
//
// Ports:
//   clk    in   1   rising-edge clock
//   rst_n  in   1   asynchronous active-low reset
//   start  in   1   division request, sampled only in IDLE
//   A      in  32   dividend, captured on accepted start
//   B      in  32   divisor, captured on accepted start
//   busy   out  1   high while a division is in progress
//   done   out  1   one-cycle pulse when outp is updated
//   outp   out 32   quotient, held until the next done
module fpu_div (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] outp
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] NORM = 2'd2;

`ifdef FPU_DIV_SPECIAL_EN
  // Two extra bits keep the true signed exponent for saturation.
  localparam int EW = 10;
`else
  // Only the low 8 bits are ever used, so the exponent is kept modulo 256.
  localparam int EW = 8;
`endif

  logic [1:0]    state_q, state_d;
  logic          sign_q, sign_d;
  logic [EW-1:0] exp_q, exp_d;
  logic [23:0]   mb_q, mb_d;
  logic [24:0]   r_q, r_d;
  logic [24:0]   q_q, q_d;
  logic [4:0]    count_q, count_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [31:0]   outp_q, outp_d;

  logic [EW-1:0] exp_cap_s;
  logic [EW-1:0] exp_n_s;
  logic [22:0]   frac_s;
  logic          ge_s;
  logic [23:0]   diff_s;

  assign busy = busy_q;
  assign done = done_q;
  assign outp = outp_q;

  // Biased quotient exponent from the raw operand fields.
`ifdef FPU_DIV_SPECIAL_EN
  assign exp_cap_s = {2'b00, A[30:23]} - {2'b00, B[30:23]} + 10'd127;
`else
  assign exp_cap_s = A[30:23] - B[30:23] + 8'd127;
`endif

  // Restoring step: compare the partial remainder against the divisor.
  // When r >= mb the difference is below mb, so 24 bits hold it exactly.
  always_comb begin
    ge_s   = (r_q >= {1'b0, mb_q});
    diff_s = r_q[23:0] - mb_q;
  end

  // Normalise: a leading quotient bit in q[24] keeps the exponent, else shift.
  always_comb begin
    if (q_q[24]) begin
      frac_s  = q_q[23:1];
      exp_n_s = exp_q;
    end else begin
      frac_s  = q_q[22:0];
      exp_n_s = exp_q - EW'(1);
    end
  end

`ifdef FPU_DIV_SPECIAL_EN
  logic        a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s;
  logic        special_s;
  logic [31:0] special_val_s;

  // Operand classification and special-case result selection.
  always_comb begin
    a_zero_s = (A[30:23] == 8'h00);
    b_zero_s = (B[30:23] == 8'h00);
    a_inf_s  = (A[30:23] == 8'hFF) && (A[22:0] == 23'h0);
    b_inf_s  = (B[30:23] == 8'hFF) && (B[22:0] == 23'h0);
    a_nan_s  = (A[30:23] == 8'hFF) && (A[22:0] != 23'h0);
    b_nan_s  = (B[30:23] == 8'hFF) && (B[22:0] != 23'h0);
    special_s     = 1'b1;
    special_val_s = 32'h0;
    if (a_nan_s || b_nan_s || (a_zero_s && b_zero_s) || (a_inf_s && b_inf_s)) begin
      special_val_s = 32'h7FC0_0000;
    end else if (b_zero_s || a_inf_s) begin
      special_val_s = {A[31] ^ B[31], 8'hFF, 23'h0};
    end else if (a_zero_s || b_inf_s) begin
      special_val_s = {A[31] ^ B[31], 31'h0};
    end else begin
      special_s = 1'b0;
    end
  end
`endif

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    mb_d    = mb_q;
    r_d     = r_q;
    q_d     = q_q;
    count_d = count_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    outp_d  = outp_q;
    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef FPU_DIV_SPECIAL_EN
          if (special_s) begin
            outp_d = special_val_s;
            done_d = 1'b1;
            busy_d = 1'b0;
          end else begin
            sign_d  = A[31] ^ B[31];
            exp_d   = exp_cap_s;
            mb_d    = {1'b1, B[22:0]};
            r_d     = {2'b01, A[22:0]};
            q_d     = 25'h0;
            count_d = 5'd0;
            busy_d  = 1'b1;
            state_d = CALC;
          end
`else
          sign_d  = A[31] ^ B[31];
          exp_d   = exp_cap_s;
          mb_d    = {1'b1, B[22:0]};
          r_d     = {2'b01, A[22:0]};
          q_d     = 25'h0;
          count_d = 5'd0;
          busy_d  = 1'b1;
          state_d = CALC;
`endif
        end else begin
          busy_d = 1'b0;
        end
      end
      CALC: begin
        // Shifting bits in from the right lands the first bit at q[24].
        if (ge_s) begin
          q_d = {q_q[23:0], 1'b1};
          r_d = {diff_s, 1'b0};
        end else begin
          q_d = {q_q[23:0], 1'b0};
          r_d = {r_q[23:0], 1'b0};
        end
        count_d = count_q + 5'd1;
        if (count_q == 5'd24) begin
          state_d = NORM;
        end else begin
          state_d = CALC;
        end
      end
      NORM: begin
`ifdef FPU_DIV_SPECIAL_EN
        if ($signed(exp_n_s) >= $signed(10'sd255)) begin
          outp_d = {sign_q, 8'hFF, 23'h0};
        end else if ($signed(exp_n_s) <= $signed(10'sd0)) begin
          outp_d = {sign_q, 31'h0};
        end else begin
          outp_d = {sign_q, exp_n_s[7:0], frac_s};
        end
`else
        outp_d = {sign_q, exp_n_s[7:0], frac_s};
`endif
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      mb_q    <= 24'h0;
      r_q     <= 25'h0;
      q_q     <= 25'h0;
      count_q <= 5'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      outp_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      mb_q    <= mb_d;
      r_q     <= r_d;
      q_q     <= q_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      outp_q  <= outp_d;
    end
  end

endmodule
